// File: rtl/hack_mem_pkg.sv
// Shared constants for the Hack data-memory / memory-mapped I/O stage:
// I/O register addresses and the UART transmitter state encoding.
package hack_mem_pkg;

  localparam logic [15:0] ADDR_LED     = 16'h4000;
  localparam logic [15:0] ADDR_UART_TX = 16'h4001;
  localparam logic [15:0] ADDR_UART_ST = 16'h4002;
  localparam logic [15:0] ADDR_BUT     = 16'h6000;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uartState_e;

endpackage

// File: rtl/hack_uart_tx.sv
// Byte-wide 8N1 UART transmitter, LSB first. A start pulse in IDLE latches the
// byte; starts while busy are ignored. Line and busy are registered outputs.
module hack_uart_tx
  import hack_mem_pkg::*;
#(
  parameter int BAUD_DIV = 217
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  uartState_e    state_r, stateNext_s;
  logic [BW-1:0] baudCnt_r, baudNext_s;
  logic [2:0]    bitCnt_r, bitNext_s;
  logic [7:0]    data_r, dataNext_s;
  logic          tx_r, txNext_s;
  logic          busy_r, busyNext_s;
  logic          baudWrap_s;

  assign baudWrap_s = (baudCnt_r == BAUD_LAST);

  // Register the FSM state, counters, latched byte and the line/busy outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= UART_IDLE;
      baudCnt_r <= '0;
      bitCnt_r  <= 3'd0;
      data_r    <= 8'h00;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= stateNext_s;
      baudCnt_r <= baudNext_s;
      bitCnt_r  <= bitNext_s;
      data_r    <= dataNext_s;
      tx_r      <= txNext_s;
      busy_r    <= busyNext_s;
    end
  end

  // Next-state logic; the line value is precomputed so tx changes exactly on bit boundaries.
  always_comb begin
    stateNext_s = state_r;
    baudNext_s  = baudCnt_r;
    bitNext_s   = bitCnt_r;
    dataNext_s  = data_r;
    txNext_s    = tx_r;
    busyNext_s  = busy_r;
    case (state_r)
      UART_IDLE: begin
        if (start) begin
          stateNext_s = UART_START;
          dataNext_s  = data;
          txNext_s    = 1'b0;
          busyNext_s  = 1'b1;
          baudNext_s  = '0;
          bitNext_s   = 3'd0;
        end else begin
          baudNext_s = '0;
          bitNext_s  = 3'd0;
          txNext_s   = 1'b1;
          busyNext_s = 1'b0;
        end
      end
      UART_START: begin
        if (baudWrap_s) begin
          stateNext_s = UART_DATA;
          baudNext_s  = '0;
          bitNext_s   = 3'd0;
          txNext_s    = data_r[0];
        end else begin
          baudNext_s = baudCnt_r + BW'(1);
        end
      end
      UART_DATA: begin
        if (baudWrap_s) begin
          baudNext_s = '0;
          if (bitCnt_r == 3'd7) begin
            stateNext_s = UART_STOP;
            bitNext_s   = 3'd0;
            txNext_s    = 1'b1;
          end else begin
            bitNext_s = bitCnt_r + 3'd1;
            txNext_s  = data_r[bitCnt_r + 3'd1];
          end
        end else begin
          baudNext_s = baudCnt_r + BW'(1);
        end
      end
      UART_STOP: begin
        if (baudWrap_s) begin
          stateNext_s = UART_IDLE;
          baudNext_s  = '0;
          busyNext_s  = 1'b0;
          txNext_s    = 1'b1;
        end else begin
          baudNext_s = baudCnt_r + BW'(1);
        end
      end
      default: begin
        stateNext_s = UART_IDLE;
        baudNext_s  = '0;
        bitNext_s   = 3'd0;
        txNext_s    = 1'b1;
        busyNext_s  = 1'b0;
      end
    endcase
  end

  assign busy = busy_r;
  assign tx   = tx_r;

endmodule

// File: rtl/hack_mem_io.sv
// Hack data memory and memory-mapped I/O: RAM, LED register, synchronised
// buttons and a UART transmitter, with a combinational read path to inM.
module hack_mem_io
  import hack_mem_pkg::*;
#(
  parameter int RAM_WORDS = 2048,
  parameter int BAUD_DIV  = 217,
  parameter int NBUT      = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [15:0]     addressM,
  input  logic [15:0]     dataM,
  input  logic            writeM,
  output logic [15:0]     inM,
  input  logic [NBUT-1:0] but,
  output logic [15:0]     led,
  output logic            uart_tx
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam logic [15:0] RAM_TOP = 16'(RAM_WORDS);

  logic [15:0]     ram_r [RAM_WORDS];
  logic [15:0]     led_r;
  logic [NBUT-1:0] butMeta_r, butSync_r;
  logic            ramSel_s;
  logic [AW-1:0]   ramIdx_s;
  logic            uartStart_s;
  logic            uartBusy_s;
  logic [15:0]     rdData_s;

  assign ramSel_s    = (addressM < RAM_TOP);
  assign ramIdx_s    = addressM[AW-1:0];
  assign uartStart_s = writeM && (addressM == ADDR_UART_TX);

  // Data RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (writeM && ramSel_s) begin
      ram_r[ramIdx_s] <= dataM;
    end
  end

  // LED register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_r <= 16'h0000;
    end else if (writeM && (addressM == ADDR_LED)) begin
      led_r <= dataM;
    end
  end

  // Two-flop synchroniser for the asynchronous button levels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      butMeta_r <= '0;
      butSync_r <= '0;
    end else begin
      butMeta_r <= but;
      butSync_r <= butMeta_r;
    end
  end

  hack_uart_tx #(
    .BAUD_DIV(BAUD_DIV)
  ) uUart (
    .clk  (clk),
    .reset(reset),
    .start(uartStart_s),
    .data (dataM[7:0]),
    .busy (uartBusy_s),
    .tx   (uart_tx)
  );

  // Zero-latency read mux; unmapped and write-only locations read as 0.
  always_comb begin
    rdData_s = 16'h0000;
    if (ramSel_s) begin
      rdData_s = ram_r[ramIdx_s];
    end else begin
      case (addressM)
        ADDR_LED:     rdData_s = led_r;
        ADDR_UART_ST: rdData_s = {15'h0000, uartBusy_s};
        ADDR_BUT:     rdData_s = 16'(butSync_r);
        default:      rdData_s = 16'h0000;
      endcase
    end
  end

  assign inM = rdData_s;
  assign led = led_r;

endmodule
